// File: rtl/adder27_pkg.sv
// +---------------------------------------------------------------------------+
// | adder27_pkg : shared state encoding, tree constants, round-robin picker   |
// | Revision    : 1.0                                                         |
// +---------------------------------------------------------------------------+
`default_nettype none

package adder27_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_INPUTS = 27;
    localparam int SUM_GUARD  = 5;
    localparam int MAX_REQ    = 8;

    // Reverse scan so the first valid requester at or after ptr wins.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 num_req);
        logic [2:0] pick;
        int         idx;
        pick = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < num_req) begin
                idx = (int'(ptr) + k) % num_req;
                if (valid[idx[2:0]]) begin
                    pick = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder27_rr_scheduler_if.sv
// +---------------------------------------------------------------------------+
// | adder27_rr_scheduler_if : requester/result bundle; ADDER27_SAT_EN adds    |
// | the sticky sat_flag. Revision : 1.0                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

interface adder27_rr_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 14
);
    import adder27_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ-1:0]                       req_ready;
    logic [NUM_REQ-1:0]                       req_last;
    logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data;
    logic                                     res_valid;
    logic [ID_W-1:0]                          res_id;
    logic                                     res_last;
    logic [DATA_WIDTH-1:0]                    res_data;
    logic                                     busy;
`ifdef ADDER27_SAT_EN
    logic                                     sat_flag;

    modport master (output req_valid, req_last, req_data,
                    input  req_ready, res_valid, res_id, res_last, res_data, busy, sat_flag);
    modport slave  (input  req_valid, req_last, req_data,
                    output req_ready, res_valid, res_id, res_last, res_data, busy, sat_flag);
`else
    modport master (output req_valid, req_last, req_data,
                    input  req_ready, res_valid, res_id, res_last, res_data, busy);
    modport slave  (input  req_valid, req_last, req_data,
                    output req_ready, res_valid, res_id, res_last, res_data, busy);
`endif

endinterface

`default_nettype wire

// File: rtl/adder27_pipe.sv
// +---------------------------------------------------------------------------+
// | adder27_pipe : 27-operand balanced adder tree with ID/last sideband;      |
// | wraps or (ADDER27_SAT_EN) saturates at the output stage. Revision : 1.0   |
// +---------------------------------------------------------------------------+
`default_nettype none

module adder27_pipe
    import adder27_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int ID_W       = 2,
    parameter int PIPE_LAT   = 5
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           in_valid_i,
    input  wire logic [ID_W-1:0]                in_id_i,
    input  wire logic                           in_last_i,
    input  wire logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data_i,
    output logic                                res_valid_o,
    output logic [ID_W-1:0]                     res_id_o,
    output logic                                res_last_o,
    output logic [DATA_WIDTH-1:0]               res_data_o,
`ifdef ADDER27_SAT_EN
    output logic                                sat_flag_o,
`endif
    output logic                                busy_o
);

    localparam int SUM_W = DATA_WIDTH + SUM_GUARD;
    localparam logic [SUM_W-1:0] DATA_MAX = SUM_W'((1 << DATA_WIDTH) - 1);

    logic [SUM_W-1:0]      opnd   [NUM_INPUTS];
    logic [SUM_W-1:0]      lvl1_d [14];
    logic [SUM_W-1:0]      lvl1_q [14];
    logic [SUM_W-1:0]      lvl2_d [7];
    logic [SUM_W-1:0]      lvl2_q [7];
    logic [SUM_W-1:0]      lvl3_d [4];
    logic [SUM_W-1:0]      lvl3_q [4];
    logic [SUM_W-1:0]      lvl4_d [2];
    logic [SUM_W-1:0]      lvl4_q [2];
    logic [SUM_W-1:0]      lvl5_d;
    logic [SUM_W-1:0]      lvl5_q;
    logic [PIPE_LAT-1:0]   vld_q;
    logic [PIPE_LAT-1:0]   last_q;
    logic [ID_W-1:0]       id_q   [PIPE_LAT];
    logic [DATA_WIDTH-1:0] final_data;

    // Odd leftovers at levels 1 and 3 ride through unpaired.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            opnd[i] = SUM_W'(in_data_i[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int j = 0; j < 13; j++) lvl1_d[j] = opnd[2*j] + opnd[2*j+1];
        lvl1_d[13] = opnd[26];
        for (int j = 0; j < 7; j++) lvl2_d[j] = lvl1_q[2*j] + lvl1_q[2*j+1];
        for (int j = 0; j < 3; j++) lvl3_d[j] = lvl2_q[2*j] + lvl2_q[2*j+1];
        lvl3_d[3] = lvl2_q[6];
        for (int j = 0; j < 2; j++) lvl4_d[j] = lvl3_q[2*j] + lvl3_q[2*j+1];
        lvl5_d = lvl4_q[0] + lvl4_q[1];
    end

`ifdef ADDER27_SAT_EN
    logic over;
    assign over       = (lvl5_q > DATA_MAX);
    assign final_data = over ? DATA_MAX[DATA_WIDTH-1:0] : lvl5_q[DATA_WIDTH-1:0];
`else
    logic unused_hi;
    assign unused_hi  = ^{lvl5_q[SUM_W-1:DATA_WIDTH], DATA_MAX};
    assign final_data = lvl5_q[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl1_q      <= '{default: '0};
            lvl2_q      <= '{default: '0};
            lvl3_q      <= '{default: '0};
            lvl4_q      <= '{default: '0};
            lvl5_q      <= '0;
            vld_q       <= '0;
            last_q      <= '0;
            id_q        <= '{default: '0};
            res_valid_o <= 1'b0;
            res_id_o    <= '0;
            res_last_o  <= 1'b0;
            res_data_o  <= '0;
`ifdef ADDER27_SAT_EN
            sat_flag_o  <= 1'b0;
`endif
        end else begin
            lvl1_q <= lvl1_d;
            lvl2_q <= lvl2_d;
            lvl3_q <= lvl3_d;
            lvl4_q <= lvl4_d;
            lvl5_q <= lvl5_d;
            vld_q  <= {vld_q[PIPE_LAT-2:0], in_valid_i};
            last_q <= {last_q[PIPE_LAT-2:0], in_last_i};
            for (int p = PIPE_LAT - 1; p > 0; p--) id_q[p] <= id_q[p-1];
            id_q[0]     <= in_id_i;
            res_valid_o <= vld_q[PIPE_LAT-1];
            // Result fields hold between strobes.
            if (vld_q[PIPE_LAT-1]) begin
                res_id_o   <= id_q[PIPE_LAT-1];
                res_last_o <= last_q[PIPE_LAT-1];
                res_data_o <= final_data;
`ifdef ADDER27_SAT_EN
                if (over) sat_flag_o <= 1'b1;
`endif
            end
        end
    end

    assign busy_o = (|vld_q) | res_valid_o;

endmodule

`default_nettype wire

// File: rtl/adder27_rr_scheduler.sv
// +---------------------------------------------------------------------------+
// | adder27_rr_scheduler : round-robin burst arbiter feeding a shared 27-in   |
// | adder tree; ADDER27_SAT_EN selects saturation. Revision : 1.0             |
// +---------------------------------------------------------------------------+
`default_nettype none

module adder27_rr_scheduler
    import adder27_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 14,
    parameter int PIPE_LAT   = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    adder27_rr_scheduler_if.slave bus
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int BEAT_W = NUM_INPUTS * DATA_WIDTH;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]  ready;
    logic                accept;
    logic [MAX_REQ-1:0]  valid_ext;
    logic [2:0]          pick_full;
    logic [BEAT_W-1:0]   beat_data;
    logic                pipe_busy;

    always_comb begin
        valid_ext = '0;
        for (int r = 0; r < NUM_REQ; r++) valid_ext[r] = bus.req_valid[r];
        pick_full = rr_pick(valid_ext, 3'(rr_ptr_q), NUM_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    // The IDLE cycle between bursts is the arbitration slot.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        ready    = '0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    grant_d = pick_full[ID_W-1:0];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ready[grant_q] = 1'b1;
                if (bus.req_valid[grant_q]) begin
                    accept = 1'b1;
                    if (bus.req_last[grant_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_data = bus.req_data[int'(grant_q)*BEAT_W +: BEAT_W];
    end

    adder27_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_W       (ID_W),
        .PIPE_LAT   (PIPE_LAT)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (accept),
        .in_id_i     (grant_q),
        .in_last_i   (bus.req_last[grant_q]),
        .in_data_i   (beat_data),
        .res_valid_o (bus.res_valid),
        .res_id_o    (bus.res_id),
        .res_last_o  (bus.res_last),
        .res_data_o  (bus.res_data),
`ifdef ADDER27_SAT_EN
        .sat_flag_o  (bus.sat_flag),
`endif
        .busy_o      (pipe_busy)
    );

    assign bus.req_ready = ready;
    assign bus.busy      = (state_q == GRANT) | pipe_busy;

endmodule

`default_nettype wire

// File: tb/tb_adder27_rr_scheduler.sv
// +---------------------------------------------------------------------------+
// | tb_adder27_rr_scheduler : directed + random bursts against a transaction  |
// | model of the scheduler; honours ADDER27_SAT_EN. Revision : 1.0            |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_adder27_rr_scheduler;
    import adder27_pkg::*;

    localparam int NR   = 4;
    localparam int DW   = 14;
    localparam int LAT  = 5;
    localparam int DMAX = (1 << DW) - 1;

    typedef struct {
        int id;
        int last;
        int data;
        int due;
        bit over;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adder27_rr_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    adder27_rr_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PIPE_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // requester-side stimulus state
    bit          rv     [NR];
    bit          rl     [NR];
    logic [DW-1:0] ops  [NR][NUM_INPUTS];
    int          left   [NR];
    int          budget [NR];
    int          fixed_len;
    int          prob;

    // transaction model
    int   owner;
    int   ptr;
    bit   exp_sat;
    res_t expq[$];

    int got_id[$];
    int got_data[$];
    int got_last[$];
    int got_step[$];

    int cyc;
    int total;
    int bad;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fill_ops(input int r, input int mode);
        for (int i = 0; i < NUM_INPUTS; i++) begin
            case (mode)
                0:       ops[r][i] = DW'(1);
                1:       ops[r][i] = DW'(DMAX);
                2:       ops[r][i] = '0;
                default: ops[r][i] = DW'($urandom_range(0, DMAX));
            endcase
        end
    endtask

    task automatic offer(input int r, input int last, input int mode);
        rv[r] = 1'b1;
        rl[r] = last[0];
        fill_ops(r, mode);
    endtask

    function automatic int raw_sum(input int r);
        int s = 0;
        for (int i = 0; i < NUM_INPUTS; i++) s += int'(ops[r][i]);
        return s;
    endfunction

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            bus.req_valid[r] = rv[r];
            bus.req_last[r]  = rl[r];
            for (int i = 0; i < NUM_INPUTS; i++)
                bus.req_data[(r*NUM_INPUTS+i)*DW +: DW] = ops[r][i];
        end
    endtask

    task automatic gen_auto();
        int m;
        for (int r = 0; r < NR; r++) begin
            if (!rv[r] && (left[r] > 0 || budget[r] > 0) && $urandom_range(0, 99) < prob) begin
                if (left[r] == 0) begin
                    left[r] = (fixed_len > 0) ? fixed_len : $urandom_range(1, 4);
                    budget[r]--;
                end
                m = $urandom_range(0, 7);
                rv[r] = 1'b1;
                rl[r] = (left[r] == 1);
                fill_ops(r, (m < 3) ? m : 3);
            end
        end
    endtask

    task automatic clear_stim();
        for (int r = 0; r < NR; r++) begin
            rv[r] = 1'b0; rl[r] = 1'b0; left[r] = 0; budget[r] = 0;
        end
    endtask

    task automatic clear_got();
        got_id.delete(); got_data.delete(); got_last.delete(); got_step.delete();
    endtask

    // One clock: drive at negedge, compare against the model, then let the
    // model decide what the coming posedge does.
    task automatic step();
        res_t e;
        int   exp_ready;
        int   s;
        int   r;
        bit   anyv;
        @(negedge clk);
        gen_auto();
        drive();
        #1;
        if (!rst) begin
            owner = -1; ptr = 0; exp_sat = 1'b0; expq.delete();
        end
        exp_ready = (owner >= 0) ? (1 << owner) : 0;
        chk("req_ready", int'(bus.req_ready), exp_ready);
        if (bus.res_valid) begin
            got_id.push_back(int'(bus.res_id));
            got_data.push_back(int'(bus.res_data));
            got_last.push_back(int'(bus.res_last));
            got_step.push_back(cyc);
        end
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            if (e.over) exp_sat = 1'b1;
            chk("res_valid", int'(bus.res_valid), 1);
            chk("res_id",    int'(bus.res_id),    e.id);
            chk("res_last",  int'(bus.res_last),  e.last);
            chk("res_data",  int'(bus.res_data),  e.data);
        end else begin
            chk("res_valid_idle", int'(bus.res_valid), 0);
        end
`ifdef ADDER27_SAT_EN
        chk("sat_flag", int'(bus.sat_flag), int'(exp_sat));
`endif
        if (rst) begin
            if (owner < 0) begin
                anyv = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    if (!anyv && rv[(ptr + k) % NR]) begin
                        owner = (ptr + k) % NR;
                        anyv  = 1'b1;
                    end
                end
            end else if (rv[owner]) begin
                r      = owner;
                s      = raw_sum(r);
                e.id   = r;
                e.last = int'(rl[r]);
                e.over = (s > DMAX);
`ifdef ADDER27_SAT_EN
                e.data = (s > DMAX) ? DMAX : s;
`else
                e.data = s % (DMAX + 1);
`endif
                e.due  = cyc + LAT + 1;
                expq.push_back(e);
                rv[r] = 1'b0;
                if (left[r] > 0) left[r]--;
                if (e.last != 0) begin
                    ptr   = (r + 1) % NR;
                    owner = -1;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        int s0;
        int guard;
        bit pend;
        int lasts[$];
        int lsteps[$];

        total = 0; bad = 0; cyc = 0;
        owner = -1; ptr = 0; exp_sat = 1'b0;
        prob = 0; fixed_len = 0;
        clear_stim();
        for (int r = 0; r < NR; r++) fill_ops(r, 2);
        rst = 1'b0;
        drive();
        #1;
        chk("rst_ready",     int'(bus.req_ready), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_id",    int'(bus.res_id),    0);
        chk("rst_res_last",  int'(bus.res_last),  0);
        chk("rst_res_data",  int'(bus.res_data),  0);
        chk("rst_busy",      int'(bus.busy),      0);
        repeat (2) step();
        rst = 1'b1;

        // single beat from requester 1, all operands 1
        clear_got();
        s0 = cyc;
        offer(1, 1, 0);
        step();
        step();
        chk("t1_ready_grant", int'(bus.req_ready), 4'b0010);
        chk("t1_busy_grant",  int'(bus.busy), 1);
        repeat (8) step();
        chk("t1_count", got_id.size(), 1);
        if (got_id.size() > 0) begin
            chk("t1_id",   got_id[0],   1);
            chk("t1_data", got_data[0], 27);
            chk("t1_last", got_last[0], 1);
            chk("t1_step", got_step[0] - s0, 7);
        end
        chk("t1_busy_after", int'(bus.busy), 0);

        // all operands at maximum from requester 3
        clear_got();
        offer(3, 1, 1);
        repeat (10) step();
        chk("t3_count", got_id.size(), 1);
        if (got_id.size() > 0) begin
            chk("t3_id", got_id[0], 3);
`ifdef ADDER27_SAT_EN
            chk("t3_data_sat", got_data[0], 16383);
`else
            chk("t3_data_wrap", got_data[0], 16357);
`endif
        end
`ifdef ADDER27_SAT_EN
        chk("t3_sat_flag", int'(bus.sat_flag), 1);
`endif

        // requesters 0 and 2 continuously valid, 3-beat bursts
        clear_got();
        budget[0] = 2; budget[2] = 2; fixed_len = 3; prob = 100;
        s0 = cyc;
        repeat (24) step();
        prob = 0; fixed_len = 0;
        for (int k = 0; k < got_id.size(); k++) begin
            if (got_last[k] != 0) begin
                lasts.push_back(got_id[k]);
                lsteps.push_back(got_step[k]);
            end
        end
        chk("t2_beats",  got_id.size(), 12);
        chk("t2_bursts", lasts.size(),  4);
        for (int k = 0; k < lasts.size() && k < 4; k++)
            chk("t2_order", lasts[k], (k % 2 == 0) ? 0 : 2);
        if (lsteps.size() == 4) chk("t2_bubble_timing", lsteps[3] - s0, 21);

        // requester 3 pauses mid-burst while requester 0 waits
        clear_got();
        offer(3, 0, 3);
        step();
        offer(0, 1, 3);
        step();
        chk("t4_ready_first", int'(bus.req_ready), 4'b1000);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_ready_hold", int'(bus.req_ready), 4'b1000);
        end
        offer(3, 1, 3);
        step();
        step();
        chk("t4_ready_bubble", int'(bus.req_ready), 4'b0000);
        step();
        chk("t4_ready_next", int'(bus.req_ready), 4'b0001);
        repeat (8) step();
        chk("t4_count", got_id.size(), 3);
        if (got_id.size() == 3) chk("t4_third_id", got_id[2], 0);

        // pointer wraps from 3 back to 0
        clear_got();
        offer(3, 1, 3);
        repeat (2) step();
        offer(0, 1, 3);
        offer(1, 1, 3);
        repeat (2) step();
        chk("t6_ready_wrap", int'(bus.req_ready), 4'b0001);
        repeat (10) step();
        chk("t6_count", got_id.size(), 3);
        if (got_id.size() == 3) begin
            chk("t6_second_id", got_id[1], 0);
            chk("t6_third_id",  got_id[2], 1);
        end

        // reset with two beats in flight
        clear_got();
        offer(1, 0, 3);
        repeat (2) step();
        offer(1, 0, 3);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        clear_stim();
        rst = 1'b1;
        offer(0, 1, 3);
        offer(2, 1, 3);
        repeat (2) step();
        chk("t5_ready_after_rst", int'(bus.req_ready), 4'b0001);
        repeat (10) step();
        chk("t5_count", got_id.size(), 2);
        if (got_id.size() == 2) begin
            chk("t5_first_id",  got_id[0], 0);
            chk("t5_second_id", got_id[1], 2);
        end

        // random traffic
        for (int r = 0; r < NR; r++) budget[r] = 1000;
        prob = 60;
        repeat (600) step();
        for (int r = 0; r < NR; r++) budget[r] = 0;
        guard = 0;
        pend  = 1'b1;
        while (pend && guard < 300) begin
            step();
            guard++;
            pend = (expq.size() > 0);
            for (int r = 0; r < NR; r++) if (rv[r] || left[r] > 0) pend = 1'b1;
        end
        chk("drain_bound", int'(guard < 300), 1);
        repeat (3) step();
        chk("final_busy", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adder27_rr_scheduler.md
Name: adder27_rr_scheduler

Overview:
- Shares one pipelined 27-input adder tree among NUM_REQ convolution requesters, e.g. PE groups producing 3x3x3 products.
- Arbitrates round-robin and locks the grant for a burst (req_last terminates it).
- Tags each beat with the requester ID and returns the truncated sum with ID and last flag after a fixed pipeline latency.
- Sits between PE product generators and the accumulation/activation stage.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 14, width of each input operand and of res_data
NUM_INPUTS, 27, operands per beat (fixed tree shape; 27 only)
PIPE_LAT, 5, adder tree pipeline depth in cycles
ID_W (localparam), clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accepted this cycle when valid&ready
req_last  in  NUM_REQ  beat is last of requester's burst
req_data  in  NUM_REQ*NUM_INPUTS*DATA_WIDTH  requester r occupies slice r; operand i at [i*DATA_WIDTH +: DATA_WIDTH]
res_valid  out  1  result strobe, one cycle per accepted beat
res_id  out  ID_W  requester that issued the beat
res_last  out  1  copy of req_last of that beat
res_data  out  DATA_WIDTH  sum of 27 operands, unsigned, truncated
busy  out  1  high when state is GRANT or any pipeline stage is valid

Behaviour:
- Reset (rst=0, async): state IDLE, rr_ptr=0, grant_id=0, all pipeline valid bits 0, req_ready=0, res_valid=0, res_id=0, res_last=0, res_data=0, busy=0.
- State IDLE:
  - req_ready=0.
  - If any req_valid, grant_id <= first r with req_valid[r]=1, searching rr_ptr, rr_ptr+1, ... with modulo NUM_REQ wrap. Next state GRANT.
  - Else stay IDLE.
- State GRANT:
  - req_ready[grant_id]=1; all other ready bits 0.
  - Beat accepted when req_valid[grant_id]=1. Accepted data, ID and last enter pipeline stage 1 at that edge.
  - If the accepted beat has req_last=1: next state IDLE, rr_ptr <= (grant_id+1) mod NUM_REQ.
  - If req_valid[grant_id] drops mid-burst: grant is held, no beat enters, no timeout.
- Throughput:
  - 1 beat/cycle within a burst.
  - Exactly one IDLE arbitration bubble cycle between bursts.
  - A single requester re-requesting continuously is re-granted after the bubble only if no other requester is valid.
- Latency: beat accepted at edge k -> res_valid=1 for the cycle following edge k+PIPE_LAT, with matching res_id/res_last/res_data. Results appear in acceptance order.
- No result back-pressure. The consumer must sink one result per cycle.
- res_data, res_id and res_last hold their last value when res_valid=0.
- Arithmetic:
  - Operands are unsigned.
  - Internal sums are DATA_WIDTH+5 bits (no internal overflow).
  - res_data = full_sum[DATA_WIDTH-1:0], i.e. wraps modulo 2^DATA_WIDTH.
- Pipeline valid/ID/last shift registers advance every cycle regardless of input, so in-flight beats always drain.
- Reset mid-burst: in-flight beats are discarded (no res_valid), and arbitration restarts from requester 0.
- req_valid/req_last of non-granted requesters are ignored. Requesters must hold data until ready.

Optional Feature:
ADDER27_SAT_EN
- Defined: if full_sum > 2^DATA_WIDTH-1, res_data = 2^DATA_WIDTH-1 (saturate). Adds an output sticky flag port sat_flag, set on any saturating result and cleared only by reset.
- Undefined: wrap-around truncation as above; no sat_flag port.
- Latency is unchanged in both cases.

Decomposition:
- Shared package adder27_pkg holds:
  - state enum (IDLE, GRANT);
  - NUM_INPUTS=27;
  - SUM_GUARD=5 (extra bits);
  - function rr_pick(valid vector, ptr) returning the next ID.
- One sub-module adder27_pipe:
  - 5-stage balanced tree (14 pairs -> 7 -> 4 -> 2 -> 1), unpaired terms passed through;
  - valid and sideband (ID+last) carried alongside;
  - truncation/saturation at the final stage.
- The top module holds the FSM, rr_ptr, ready decode and input mux.

Test Plan:
- Reset, then requester 1 sends a single beat, all operands 1, last=1 -> grant cycle, then one beat; 5 cycles later res_valid=1, res_id=1, res_data=27, res_last=1; busy=0 afterwards.
- Requesters 0 and 2 both valid continuously with 3-beat bursts -> grant order 0, 2, 0, 2; results keep burst order; one idle bubble between bursts.
- All operands 0x3FFF (DATA_WIDTH=14) -> full sum 442341, res_data=0x3FE5 (wrap). With ADDER27_SAT_EN: res_data=0x3FFF and sat_flag=1.
- Requester 3 drops valid for 4 cycles mid-burst while requester 0 is valid -> req_ready[0] stays 0, grant stays on 3, burst completes, then 0 is granted.
- rst asserted 2 cycles after accepting 2 beats -> no res_valid for those beats; after release, rr_ptr=0 and requester 0 wins the tie with 2.
- rr_ptr wrap: last grant was 3, requesters 0 and 1 valid -> requester 0 granted.
